apb_master_bridge: RTL and testbench

- Upstream APB master that feeds all APB peripherals in the RV32I SoC, including GPO, GPI, UART and timer.
- Converts the core's simple request/ready data-bus accesses into APB SETUP/ACCESS transfers.
- Decodes the address into a one-hot PSEL and muxes the selected slave's PRDATA/PREADY back to the core.
- Unmapped addresses get an error response; no APB transfer is issued.

---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_addr_decoder.sv | 26 ++
 rtl/apb_master_bridge.sv | 143 ++++++++++++++
 tb/tb_apb_master_bridge.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB master bridge: bus widths, peripheral
// window decode constants and the transfer state encoding.
package apb_pkg;

    localparam int unsigned APB_DATA_W     = 32;
    localparam logic [15:0] PERIPH_BASE_HI = 16'h1000;
    localparam int unsigned SLAVE_IDX_MSB  = 15;
    localparam int unsigned SLAVE_IDX_LSB  = 12;
    localparam int unsigned SLAVE_IDX_W    = SLAVE_IDX_MSB - SLAVE_IDX_LSB + 1;
    localparam logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } apb_state_e;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational peripheral-window decode: upper address bits to
// {mapped, slave index, one-hot select}.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 4,
    parameter logic [15:0] BASE_HI    = PERIPH_BASE_HI
) (
    input  logic [APB_DATA_W-1:SLAVE_IDX_LSB] addr,
    output logic                              mapped,
    output logic [SLAVE_IDX_W-1:0]            index,
    output logic [NUM_SLAVES-1:0]             sel
);

    always_comb begin
        index  = addr[SLAVE_IDX_MSB:SLAVE_IDX_LSB];
        mapped = (addr[APB_DATA_W-1:16] == BASE_HI) && (32'(index) < NUM_SLAVES);
        sel    = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (mapped && (32'(index) == i)) begin
                sel[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// Core request/ready bus to APB SETUP/ACCESS bridge with one-hot slave select.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned NUM_SLAVES     = 4,
    parameter logic [15:0] BASE_HI        = PERIPH_BASE_HI,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                             PCLK,
    input  logic                             PRESET,
    input  logic                             req,
    input  logic                             we,
    input  logic [APB_DATA_W-1:0]            addr,
    input  logic [APB_DATA_W-1:0]            wdata,
    output logic [APB_DATA_W-1:0]            rdata,
    output logic                             ready,
    output logic                             error,
    output logic [APB_DATA_W-1:0]            PADDR,
    output logic                             PWRITE,
    output logic                             PENABLE,
    output logic [APB_DATA_W-1:0]            PWDATA,
    output logic [NUM_SLAVES-1:0]            PSEL,
    input  logic [APB_DATA_W*NUM_SLAVES-1:0] PRDATA_bus,
    input  logic [NUM_SLAVES-1:0]            PREADY_bus
);

    if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_num_slaves
        $error("NUM_SLAVES must be in 1..16");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    apb_state_e               state;
    logic [SLAVE_IDX_W-1:0]   idx_q;
    logic                     dec_mapped;
    logic [SLAVE_IDX_W-1:0]   dec_index;
    logic [NUM_SLAVES-1:0]    dec_sel;
    logic                     pready_sel;
    logic [APB_DATA_W-1:0]    prdata_sel;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt;
`endif

    apb_addr_decoder #(
        .NUM_SLAVES(NUM_SLAVES),
        .BASE_HI   (BASE_HI)
    ) u_decoder (
        .addr  (addr[APB_DATA_W-1:SLAVE_IDX_LSB]),
        .mapped(dec_mapped),
        .index (dec_index),
        .sel   (dec_sel)
    );

    // Only the latched slave's PREADY/PRDATA are ever observed.
    always_comb begin
        pready_sel = 1'b0;
        prdata_sel = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (32'(idx_q) == i) begin
                pready_sel = PREADY_bus[i];
                prdata_sel = PRDATA_bus[i*APB_DATA_W +: APB_DATA_W];
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state   <= IDLE;
            idx_q   <= '0;
            rdata   <= '0;
            ready   <= 1'b0;
            error   <= 1'b0;
            PADDR   <= '0;
            PWRITE  <= 1'b0;
            PENABLE <= 1'b0;
            PWDATA  <= '0;
            PSEL    <= '0;
`ifdef APB_TIMEOUT_EN
            to_cnt  <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        PADDR  <= addr;
                        PWRITE <= we;
                        PWDATA <= wdata;
                        idx_q  <= dec_index;
                        if (dec_mapped) begin
                            PSEL  <= dec_sel;
                            state <= SETUP;
`ifdef APB_TIMEOUT_EN
                            to_cnt <= '0;
`endif
                        end else begin
                            ready <= 1'b1;
                            error <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready_sel) begin
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        ready   <= 1'b1;
                        rdata   <= PWRITE ? '0 : prdata_sel;
                        state   <= DONE;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        ready   <= 1'b1;
                        error   <= 1'b1;
                        rdata   <= TIMEOUT_RDATA;
                        state   <= DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    ready <= 1'b0;
                    error <= 1'b0;
                    rdata <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a response scoreboard and
// simple registered-PREADY slave models (slave 0 acts as a GPO register).
module tb_apb_master_bridge;

    logic         PCLK = 1'b0;
    logic         PRESET;
    logic         req;
    logic         we;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic         ready;
    logic         error;
    logic [31:0]  PADDR;
    logic         PWRITE;
    logic         PENABLE;
    logic [31:0]  PWDATA;
    logic [3:0]   PSEL;
    logic [127:0] PRDATA_bus;
    logic [3:0]   PREADY_bus;

    logic [3:0]   auto_en;
    logic [3:0]   force_rdy;
    logic [3:0]   rdy_reg;
    logic [7:0]   gpo_cr;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;
    exp_t sb[$];

    always #5 PCLK = ~PCLK;

    apb_master_bridge #(
        .NUM_SLAVES    (4),
        .BASE_HI       (16'h1000),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready),
        .error     (error),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PENABLE   (PENABLE),
        .PWDATA    (PWDATA),
        .PSEL      (PSEL),
        .PRDATA_bus(PRDATA_bus),
        .PREADY_bus(PREADY_bus)
    );

    assign PRDATA_bus = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_00A5};
    assign PREADY_bus = (auto_en & rdy_reg) | (~auto_en & force_rdy);

    // Slaves answer one cycle after PSEL && PENABLE; slave 0 holds an 8-bit control reg.
    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rdy_reg <= '0;
            gpo_cr  <= '0;
        end else begin
            rdy_reg <= PSEL & {4{PENABLE}} & ~rdy_reg;
            if (PSEL[0] && PENABLE && PREADY_bus[0] && PWRITE)
                gpo_cr <= PWDATA[7:0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic push_exp(input logic [31:0] rd, input logic err);
        exp_t e;
        e.rd  = rd;
        e.err = err;
        sb.push_back(e);
    endtask

    always @(negedge PCLK) begin
        if (ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_rdata", rdata, e.rd);
                chk("sb_error", {31'b0, error}, {31'b0, e.err});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        PRESET    = 1'b1;
        req       = 1'b0;
        we        = 1'b0;
        addr      = '0;
        wdata     = '0;
        auto_en   = 4'b1111;
        force_rdy = 4'b0000;
        tick(2);
        chk("rst_ready",   {31'b0, ready},   32'd0);
        chk("rst_error",   {31'b0, error},   32'd0);
        chk("rst_rdata",   rdata,            32'd0);
        chk("rst_psel",    {28'b0, PSEL},    32'd0);
        chk("rst_penable", {31'b0, PENABLE}, 32'd0);
        chk("rst_paddr",   PADDR,            32'd0);
        chk("rst_pwdata",  PWDATA,           32'd0);
        chk("rst_pwrite",  {31'b0, PWRITE},  32'd0);
        PRESET = 1'b0;
        tick(1);

        // Write 0xFF to GPO
        push_exp(32'h0, 1'b0);
        req = 1'b1; we = 1'b1; addr = 32'h1000_0000; wdata = 32'h0000_00FF;
        tick();
        chk("wr_c1_psel",    {28'b0, PSEL},    32'h1);
        chk("wr_c1_penable", {31'b0, PENABLE}, 32'd0);
        chk("wr_c1_paddr",   PADDR,            32'h1000_0000);
        chk("wr_c1_pwrite",  {31'b0, PWRITE},  32'd1);
        chk("wr_c1_pwdata",  PWDATA,           32'h0000_00FF);
        req = 1'b0; addr = 32'h0; wdata = 32'h0;
        tick();
        chk("wr_c2_penable", {31'b0, PENABLE}, 32'd1);
        chk("wr_c2_psel",    {28'b0, PSEL},    32'h1);
        tick();
        chk("wr_c3_penable", {31'b0, PENABLE}, 32'd1);
        chk("wr_c3_ready",   {31'b0, ready},   32'd0);
        chk("wr_c3_pwdata",  PWDATA,           32'h0000_00FF);
        tick();
        chk("wr_c4_ready",   {31'b0, ready},   32'd1);
        chk("wr_c4_psel",    {28'b0, PSEL},    32'd0);
        chk("gpo_cr",        {24'b0, gpo_cr},  32'h0000_00FF);

        // Read raised during DONE: ignored there, accepted by the following IDLE
        push_exp(32'h0000_00A5, 1'b0);
        req = 1'b1; we = 1'b0; addr = 32'h1000_0004;
        tick();
        chk("b2b_idle_ready", {31'b0, ready}, 32'd0);
        chk("b2b_idle_psel",  {28'b0, PSEL},  32'd0);
        tick();
        chk("rd_c1_psel",   {28'b0, PSEL},   32'h1);
        chk("rd_c1_pwrite", {31'b0, PWRITE}, 32'd0);
        chk("rd_c1_paddr",  PADDR,           32'h1000_0004);
        req = 1'b0;
        tick();
        chk("rd_c2_penable", {31'b0, PENABLE}, 32'd1);
        tick();
        chk("rd_c3_ready", {31'b0, ready}, 32'd0);
        tick();
        chk("rd_c4_ready", {31'b0, ready}, 32'd1);
        tick();

        // Unmapped base
        push_exp(32'h0, 1'b1);
        req = 1'b1; we = 1'b0; addr = 32'h2000_0000;
        tick();
        chk("unm_ready", {31'b0, ready}, 32'd1);
        chk("unm_error", {31'b0, error}, 32'd1);
        chk("unm_psel",  {28'b0, PSEL},  32'd0);
        req = 1'b0;
        tick();
        chk("unm_ready_clr", {31'b0, ready}, 32'd0);
        chk("unm_error_clr", {31'b0, error}, 32'd0);

        // Slave index just past the last window
        push_exp(32'h0, 1'b1);
        req = 1'b1; addr = 32'h1000_4000;
        tick();
        chk("idx4_ready",   {31'b0, ready},   32'd1);
        chk("idx4_psel",    {28'b0, PSEL},    32'd0);
        chk("idx4_penable", {31'b0, PENABLE}, 32'd0);
        req = 1'b0;
        tick();

        // Slave 3 stalls, slave 2 ready throughout and must be ignored
        auto_en = 4'b0011; force_rdy = 4'b0100;
        push_exp(32'h3333_0003, 1'b0);
        req = 1'b1; we = 1'b0; addr = 32'h1000_3000;
        tick();
        chk("stall_c1_psel", {28'b0, PSEL}, 32'h8);
        req = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            tick();
            chk("stall_penable", {31'b0, PENABLE}, 32'd1);
            chk("stall_ready",   {31'b0, ready},   32'd0);
            if (k == 3) begin
                req = 1'b1; addr = 32'h2000_0000;
            end
            if (k == 4) req = 1'b0;
            if (k == 5) chk("stall_paddr_hold", PADDR, 32'h1000_3000);
        end
        tick();
        chk("stall_c7_ready", {31'b0, ready}, 32'd0);
        force_rdy[3] = 1'b1;
        tick();
        chk("stall_c8_ready", {31'b0, ready}, 32'd1);
        force_rdy = 4'b0000; auto_en = 4'b1111;
        tick();

        // Reset during ACCESS aborts the write
        req = 1'b1; we = 1'b1; addr = 32'h1000_1000; wdata = 32'h0000_1234;
        tick();
        chk("abort_c1_psel", {28'b0, PSEL}, 32'h2);
        req = 1'b0;
        tick();
        chk("abort_c2_penable", {31'b0, PENABLE}, 32'd1);
        #2 PRESET = 1'b1;
        #1;
        chk("abort_psel",    {28'b0, PSEL},    32'd0);
        chk("abort_penable", {31'b0, PENABLE}, 32'd0);
        chk("abort_ready",   {31'b0, ready},   32'd0);
        tick();
        PRESET = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("abort_no_ready", {31'b0, ready}, 32'd0);
        end

        push_exp(32'h0, 1'b0);
        req = 1'b1; we = 1'b1; addr = 32'h1000_1000; wdata = 32'h0000_0055;
        tick();
        chk("post_c1_psel", {28'b0, PSEL}, 32'h2);
        req = 1'b0;
        tick(2);
        chk("post_c3_ready", {31'b0, ready}, 32'd0);
        tick();
        chk("post_c4_ready", {31'b0, ready}, 32'd1);
        tick();

`ifdef APB_TIMEOUT_EN
        // Slave 1 never ready: 16 ACCESS cycles then timeout response
        auto_en = 4'b1101; force_rdy = 4'b0000;
        push_exp(32'hDEAD_BEEF, 1'b1);
        req = 1'b1; we = 1'b0; addr = 32'h1000_1000;
        tick();
        req = 1'b0;
        for (int k = 2; k <= 17; k++) begin
            tick();
            chk("to_wait_ready", {31'b0, ready}, 32'd0);
        end
        tick();
        chk("to_ready", {31'b0, ready}, 32'd1);
        chk("to_psel",  {28'b0, PSEL},  32'd0);
        auto_en = 4'b1111;
        tick();
`endif

        tick(2);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
